// File: rtl/ct_pkg.sv
// Shared field layout, limits, time struct and load validation for current_time_counter.
package ct_pkg;

    localparam int CT_W       = 22;
    localparam int DAY_LSB    = 19;
    localparam int DAY_W      = 3;
    localparam int HOUR_LSB   = 14;
    localparam int HOUR_W     = 5;
    localparam int MIN_T_LSB  = 11;
    localparam int MIN_T_W    = 3;
    localparam int MIN_O_LSB  = 7;
    localparam int MIN_O_W    = 4;
    localparam int SEC_T_LSB  = 4;
    localparam int SEC_T_W    = 3;
    localparam int SEC_O_LSB  = 0;
    localparam int SEC_O_W    = 4;
    localparam int LEGACY_LSB = 7;
    localparam int LEGACY_W   = 15;

    localparam int HOUR_MAX = 23;
    localparam int TENS_MAX = 5;
    localparam int ONES_MAX = 9;

    typedef struct packed {
        logic [DAY_W-1:0]   day;
        logic [HOUR_W-1:0]  hour;
        logic [MIN_T_W-1:0] min_t;
        logic [MIN_O_W-1:0] min_o;
        logic [SEC_T_W-1:0] sec_t;
        logic [SEC_O_W-1:0] sec_o;
    } ct_time_t;

    function automatic logic ct_valid(input ct_time_t t, input int unsigned week_days);
        return (t.hour  <= HOUR_W'(HOUR_MAX)) &&
               (t.min_t <= MIN_T_W'(TENS_MAX)) &&
               (t.min_o <= MIN_O_W'(ONES_MAX)) &&
               (t.sec_t <= SEC_T_W'(TENS_MAX)) &&
               (t.sec_o <= SEC_O_W'(ONES_MAX)) &&
               (32'(t.day) < week_days);
    endfunction

endpackage

// File: rtl/ct_prescaler.sv
// Modulo-TICKS counter; tc is high on the enabled cycle that wraps the count.
module ct_prescaler #(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    input  logic load_zero,
    output logic tc
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CW-1:0] count_reg;

    assign tc = en && (count_reg == CW'(TICKS - 1));

    always_ff @(posedge clk) begin
        if (srst || load_zero) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= tc ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/current_time_counter.sv
// Day/hour/minute/second counter with prescaler, validated load and 12-hour view.
// Optional alarm compare (ATI/Match) is built when CT_ALARM_EN is defined.
module current_time_counter
    import ct_pkg::*;
#(
    parameter int TICKS_PER_SEC = 4,
    parameter int WEEK_DAYS     = 7
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic            Enable,
    input  logic            LD,
    input  logic [CT_W-1:0] CTI,
    input  logic            Mode12,
    output logic [CT_W-1:0] CTO,
    output logic [3:0]      Hour12,
    output logic            PM,
    output logic            SecTick,
    output logic            DayRoll,
`ifdef CT_ALARM_EN
    input  logic [LEGACY_W-1:0] ATI,
    output logic                Match,
`endif
    output logic            LdErr
);

    localparam logic [DAY_W-1:0] DAY_LAST = DAY_W'(WEEK_DAYS - 1);

    ct_time_t time_reg;
    ct_time_t time_next;
    ct_time_t cti_time;
    logic     sec_tick_reg;
    logic     day_roll_reg;
    logic     ld_err_reg;
    logic     day_roll_next;
    logic     ld_ok;
    logic     tick;

    assign cti_time = ct_time_t'(CTI);
    assign ld_ok    = ct_valid(cti_time, WEEK_DAYS);

    // A load (valid or not) freezes the prescaler for that edge, so a
    // coincident terminal tick is dropped rather than applied afterwards.
    ct_prescaler #(
        .TICKS     (TICKS_PER_SEC)
    ) u_prescaler (
        .clk       (Clock),
        .srst      (Clear),
        .en        (Enable && !LD),
        .load_zero (LD && ld_ok),
        .tc        (tick)
    );

    always_comb begin
        time_next     = time_reg;
        day_roll_next = 1'b0;
        if (time_reg.sec_o != SEC_O_W'(ONES_MAX)) begin
            time_next.sec_o = time_reg.sec_o + 1'b1;
        end else begin
            time_next.sec_o = '0;
            if (time_reg.sec_t != SEC_T_W'(TENS_MAX)) begin
                time_next.sec_t = time_reg.sec_t + 1'b1;
            end else begin
                time_next.sec_t = '0;
                if (time_reg.min_o != MIN_O_W'(ONES_MAX)) begin
                    time_next.min_o = time_reg.min_o + 1'b1;
                end else begin
                    time_next.min_o = '0;
                    if (time_reg.min_t != MIN_T_W'(TENS_MAX)) begin
                        time_next.min_t = time_reg.min_t + 1'b1;
                    end else begin
                        time_next.min_t = '0;
                        if (time_reg.hour != HOUR_W'(HOUR_MAX)) begin
                            time_next.hour = time_reg.hour + 1'b1;
                        end else begin
                            time_next.hour = '0;
                            day_roll_next  = 1'b1;
                            time_next.day  = (time_reg.day == DAY_LAST) ? '0 : time_reg.day + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            time_reg     <= '0;
            sec_tick_reg <= 1'b0;
            day_roll_reg <= 1'b0;
            ld_err_reg   <= 1'b0;
        end else begin
            sec_tick_reg <= 1'b0;
            day_roll_reg <= 1'b0;
            ld_err_reg   <= 1'b0;
            if (LD) begin
                if (ld_ok) begin
                    time_reg <= cti_time;
                end else begin
                    ld_err_reg <= 1'b1;
                end
            end else if (tick) begin
                time_reg     <= time_next;
                sec_tick_reg <= 1'b1;
                day_roll_reg <= day_roll_next;
            end
        end
    end

`ifdef CT_ALARM_EN
    logic match_reg;
    logic load_hit;
    logic tick_hit;

    assign load_hit = LD && ld_ok && (cti_time.sec_t == '0) && (cti_time.sec_o == '0) &&
                      (CTI[CT_W-1:LEGACY_LSB] == ATI);
    assign tick_hit = !LD && tick && (time_next.sec_t == '0) && (time_next.sec_o == '0) &&
                      (time_next[CT_W-1:LEGACY_LSB] == ATI);

    always_ff @(posedge Clock) begin
        if (Clear) begin
            match_reg <= 1'b0;
        end else begin
            match_reg <= load_hit || tick_hit;
        end
    end

    assign Match = match_reg;
`endif

    always_comb begin
        Hour12 = '0;
        PM     = 1'b0;
        if (Mode12) begin
            PM = (time_reg.hour >= 5'd12);
            if (time_reg.hour == 5'd0) begin
                Hour12 = 4'd12;
            end else if (time_reg.hour > 5'd12) begin
                Hour12 = 4'(time_reg.hour - 5'd12);
            end else begin
                Hour12 = time_reg.hour[3:0];
            end
        end
    end

    assign CTO     = time_reg;
    assign SecTick = sec_tick_reg;
    assign DayRoll = day_roll_reg;
    assign LdErr   = ld_err_reg;

endmodule

// File: tb/tb_current_time_counter.sv
// Directed bench for current_time_counter (TICKS_PER_SEC=4, WEEK_DAYS=7); alarm cases need CT_ALARM_EN.
module tb_current_time_counter;

    logic        clk = 1'b0;
    logic        clear;
    logic        enable;
    logic        ld;
    logic [21:0] cti;
    logic        mode12;
    logic [21:0] cto;
    logic [3:0]  hour12;
    logic        pm;
    logic        sec_tick;
    logic        day_roll;
    logic        ld_err;
`ifdef CT_ALARM_EN
    logic [14:0] ati;
    logic        match;
`endif

    int errors = 0;
    int checks = 0;
    int sec_pulses = 0;
    int roll_pulses = 0;
    int match_pulses = 0;
    logic [21:0] match_cto = '0;

    always #5 clk = ~clk;

    current_time_counter #(
        .TICKS_PER_SEC (4),
        .WEEK_DAYS     (7)
    ) dut (
        .Clock   (clk),
        .Clear   (clear),
        .Enable  (enable),
        .LD      (ld),
        .CTI     (cti),
        .Mode12  (mode12),
        .CTO     (cto),
        .Hour12  (hour12),
        .PM      (pm),
        .SecTick (sec_tick),
        .DayRoll (day_roll),
`ifdef CT_ALARM_EN
        .ATI     (ati),
        .Match   (match),
`endif
        .LdErr   (ld_err)
    );

    function automatic logic [21:0] mk(input int d, input int h, input int mt, input int mo,
                                       input int st, input int so);
        logic [31:0] dv, hv, mtv, mov, stv, sov;
        dv = d; hv = h; mtv = mt; mov = mo; stv = st; sov = so;
        return {dv[2:0], hv[4:0], mtv[2:0], mov[3:0], stv[2:0], sov[3:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance n clock edges, sampling pulses 1 time unit after each edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sec_tick) sec_pulses++;
            if (day_roll) roll_pulses++;
`ifdef CT_ALARM_EN
            if (match) begin
                match_pulses++;
                match_cto = cto;
            end
`endif
        end
    endtask

    initial begin
        clear = 1'b1; enable = 1'b1; ld = 1'b0; cti = '0; mode12 = 1'b0;
`ifdef CT_ALARM_EN
        ati = '0;
`endif
        run(2);
        clear = 1'b0;
        check("reset_cto", 32'(cto), 32'h0);
        check("reset_pulses", {29'd0, sec_tick, day_roll, ld_err}, 32'h0);

        sec_pulses = 0;
        run(3);
        check("no_early_inc", 32'(cto), 32'h0);
        run(1);
        check("first_inc_cto", 32'(cto), 32'(mk(0, 0, 0, 0, 0, 1)));
        check("first_inc_tick", 32'(sec_tick), 32'h1);
        run(8);
        check("three_sec_cto", 32'(cto), 32'(mk(0, 0, 0, 0, 0, 3)));
        check("three_sec_pulses", 32'(sec_pulses), 32'd3);

        roll_pulses = 0;
        ld = 1'b1; cti = mk(6, 23, 5, 9, 5, 8);
        run(1);
        ld = 1'b0;
        check("load_wrap_start", 32'(cto), 32'(mk(6, 23, 5, 9, 5, 8)));
        run(4);
        check("wrap_59", 32'(cto), 32'(mk(6, 23, 5, 9, 5, 9)));
        run(4);
        check("wrap_cto", 32'(cto), 32'h0);
        check("wrap_dayroll_now", 32'(day_roll), 32'h1);
        check("wrap_roll_count", 32'(roll_pulses), 32'd1);

        ld = 1'b1; cti = mk(2, 24, 0, 0, 0, 0);
        run(1);
        check("bad_hour_err", 32'(ld_err), 32'h1);
        check("bad_hour_cto", 32'(cto), 32'h0);
        ld = 1'b0;
        run(1);
        check("err_one_cycle", 32'(ld_err), 32'h0);

        ld = 1'b1; mode12 = 1'b1; cti = mk(2, 8, 4, 3, 0, 0);
        run(1);
        check("load_0843", 32'(cto), 32'(mk(2, 8, 4, 3, 0, 0)));
        check("h12_8am", {27'd0, pm, hour12}, {27'd0, 1'b0, 4'd8});
        cti = mk(2, 8, 6, 0, 0, 0);
        run(1);
        check("bad_mint_err", 32'(ld_err), 32'h1);
        check("bad_mint_cto", 32'(cto), 32'(mk(2, 8, 4, 3, 0, 0)));
        cti = mk(7, 1, 0, 0, 0, 0);
        run(1);
        check("bad_day_err", 32'(ld_err), 32'h1);
        cti = mk(2, 8, 0, 0, 6, 0);
        run(1);
        check("bad_sect_err", 32'(ld_err), 32'h1);
        cti = mk(2, 13, 0, 0, 0, 0);
        run(1);
        check("h12_1pm", {27'd0, pm, hour12}, {27'd0, 1'b1, 4'd1});
        check("good_no_err", 32'(ld_err), 32'h0);
        cti = mk(0, 0, 0, 0, 0, 0);
        run(1);
        check("h12_12am", {27'd0, pm, hour12}, {27'd0, 1'b0, 4'd12});
        cti = mk(0, 12, 0, 0, 0, 0);
        run(1);
        check("h12_12pm", {27'd0, pm, hour12}, {27'd0, 1'b1, 4'd12});
        cti = mk(0, 23, 0, 0, 0, 0);
        run(1);
        check("h12_11pm", {27'd0, pm, hour12}, {27'd0, 1'b1, 4'd11});
        mode12 = 1'b0;
        #1;
        check("h12_off", {27'd0, pm, hour12}, 32'h0);

        cti = mk(1, 5, 0, 0, 0, 0);
        run(1);
        ld = 1'b0;
        run(2);
        enable = 1'b0;
        sec_pulses = 0;
        run(10);
        check("hold_cto", 32'(cto), 32'(mk(1, 5, 0, 0, 0, 0)));
        check("hold_pulses", 32'(sec_pulses), 32'd0);
        enable = 1'b1;
        run(1);
        check("resume_not_yet", 32'(cto), 32'(mk(1, 5, 0, 0, 0, 0)));
        run(1);
        check("resume_inc", 32'(cto), 32'(mk(1, 5, 0, 0, 0, 1)));

        clear = 1'b1; ld = 1'b1; cti = mk(3, 4, 1, 2, 3, 4);
        run(1);
        check("clear_beats_ld", 32'(cto), 32'h0);
        clear = 1'b0; ld = 1'b0;

        run(3);
        ld = 1'b1; cti = mk(4, 10, 2, 5, 3, 7);
        run(1);
        ld = 1'b0;
        check("ld_on_tick_cto", 32'(cto), 32'(mk(4, 10, 2, 5, 3, 7)));
        check("ld_on_tick_notick", 32'(sec_tick), 32'h0);
        run(3);
        check("after_ld_hold", 32'(cto), 32'(mk(4, 10, 2, 5, 3, 7)));
        run(1);
        check("after_ld_inc", 32'(cto), 32'(mk(4, 10, 2, 5, 3, 8)));

`ifdef CT_ALARM_EN
        ati = mk(2, 8, 4, 4, 0, 0) >> 7;
        ld = 1'b1; cti = mk(2, 8, 4, 3, 5, 8);
        run(1);
        ld = 1'b0;
        match_pulses = 0;
        run(12);
        check("alarm_pulses", 32'(match_pulses), 32'd1);
        check("alarm_cto", 32'(match_cto), 32'(mk(2, 8, 4, 4, 0, 0)));
        ld = 1'b1; cti = mk(2, 8, 4, 4, 0, 0);
        run(1);
        ld = 1'b0;
        check("alarm_on_load", 32'(match), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/current_time_counter.md
# current_time_counter

Parametrised time-of-day counter with seconds resolution, on-chip prescaler, day-of-week wrap, validated load and optional 12-hour presentation. It is the next generation of `current_time_module` and keeps its 15-bit day/hour/minute word as the upper field of a wider word. It feeds the display and alarm path and is loaded by the time-set controller.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 4: Clock cycles per second. Must be ≥1; 1 means one second per enabled cycle.
- `WEEK_DAYS`, default 7: number of day codes, 1..8. Day counts 0..WEEK_DAYS-1.

Ports:
- `Clock`  in  1: sole clock, rising edge.
- `Clear`  in  1: reset, synchronous, active-high.
- `Enable`  in  1: count enable. Low freezes both the time and the prescaler.
- `LD`  in  1: load `CTI` on this edge.
- `CTI`  in  22: load word.
- `Mode12`  in  1: selects 12-hour presentation on `Hour12`/`PM`.
- `CTO`  out  22: current time.
- `Hour12`  out  4: 1..12 when `Mode12`=1, else 0.
- `PM`  out  1: hour ≥12 when `Mode12`=1, else 0.
- `SecTick`  out  1: one-cycle pulse on every seconds increment.
- `DayRoll`  out  1: one-cycle pulse on the 23:59:59→00:00:00 step.
- `LdErr`  out  1: one-cycle pulse when a load is rejected.
- `ATI`  in  15 (`CT_ALARM_EN` only): alarm day/hour/minute.
- `Match`  out  1 (`CT_ALARM_EN` only): alarm hit pulse.

## Operation
- Word layout: [21:19] day (binary); [18:14] hour (binary 0..23); [13:11] minute tens; [10:7] minute ones; [6:4] second tens; [3:0] second ones. [21:7] is identical to the legacy 15-bit format.
- Prescaler: counts 0..TICKS_PER_SEC-1 while `Enable`=1. A terminal count advances the time by one second.
- Second-advance carry chain:
  - Seconds: ones 9→0 carries into tens; tens 5→0 carries into minutes.
  - Minutes: ones 9→0 carries into tens; tens 5→0 carries into hours.
  - Hours: 23→0 increments the day.
  - Day: WEEK_DAYS-1→0.
- Load validation: a load is valid when hour ≤23, each minute and second tens ≤5, each ones ≤9, and day <WEEK_DAYS.
  - Valid load: `CTO`←`CTI` and the prescaler is zeroed.
  - Invalid load: `CTO` and the prescaler are unchanged, and `LdErr` pulses.
  - Load acts regardless of `Enable`.
- Priority: `Clear` > `LD` > count. A tick coincident with `LD` is discarded.
- `Hour12` mapping: hour 0→12 AM, 1..11→AM, 12→12 PM, 13..23→hour-12 PM. `Hour12` and `PM` are combinational from `CTO` and `Mode12`.

## Timing
- Reset: `CTO`=0 (day 0, 00:00:00), prescaler=0, and `SecTick`, `DayRoll`, `LdErr`, `Match` all 0.
- `CTO`, `SecTick`, `DayRoll`, `LdErr` and `Match` are registered.
- `SecTick` is high in the cycle after the edge that updated `CTO`, i.e. coincident with the new value.
- After reset or a valid load at edge k, with `Enable` continuously high, the first increment appears after edge k+TICKS_PER_SEC.
- `Enable` low mid-count holds the prescaler value. Counting resumes from that value with no lost or extra tick.
- `Clear` during any operation wins on that edge, including over `LD`.

## Configuration
- `CT_ALARM_EN` defined:
  - Adds `ATI` and `Match`.
  - `Match` pulses for one cycle when `CTO` steps to seconds 00 with `CTO[21:7]`==`ATI`.
  - A load that lands exactly on the match time also pulses `Match`.
- `CT_ALARM_EN` undefined: both ports and all compare logic are absent.

## Structure
- Package `ct_pkg`: field offsets and widths, the limits (23, 5, 9), the `ct_time_t` packed struct, and the `ct_valid()` function.
- Sub-module `ct_prescaler`: modulo-TICKS_PER_SEC counter with enable, synchronous clear, load-zero input and terminal-count output.

## Test plan
- Reset then 3×TICKS_PER_SEC enabled cycles → `CTO`=00:00:03 with three `SecTick` pulses.
- Load day 6, 23:59:58 (WEEK_DAYS=7), then 2 s → `CTO`=day 0 00:00:00 with one `DayRoll` pulse.
- Load hour 24 → `LdErr` pulse, `CTO` unchanged. Load 2 08:43:00 → accepted; `Mode12`=1 gives `Hour12`=8, `PM`=0. Load 13:00 → `Hour12`=1, `PM`=1.
- `Enable` dropped for 10 cycles at prescaler=2 → no increments. After re-enable, the increment lands TICKS_PER_SEC-2 cycles later.
- `Clear` and `LD` asserted together → `CTO`=0. `LD` coincident with a terminal tick → `CTO`=`CTI` exactly.
- `CT_ALARM_EN`: `ATI`=2 08:44, load 2 08:43:58 → a single `Match` pulse when `CTO`=08:44:00.
